rom_burst_reader: RTL

Burst read controller that drives the dual-port ROM (en_a/en_b, add_a/add_b) and consumes its d_ra/d_rb outputs. On a start command it reads len consecutive words from base_addr, using port A for even burst offsets and port B for odd ones. It reorders them into a single byte stream with a valid/ready handshake, buffering through an internal FIFO so downstream backpressure never drops data. It sits directly upstream of the ROM (address/enable side) and downstream of it (data side).

---
 rtl/rom_burst_reader_if.sv | 32 +++
 rtl/rom_burst_reader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader_if.sv
// Bus bundle for rom_burst_reader: burst command, dual-port ROM address/data
// and the buffered output byte stream. master = reader, slave = its environment.
interface rom_burst_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              en_a;
  logic              en_b;
  logic [ADDR_W-1:0] add_a;
  logic [ADDR_W-1:0] add_b;
  logic [DATA_W-1:0] d_ra;
  logic [DATA_W-1:0] d_rb;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, len, d_ra, d_rb, out_ready,
    output en_a, en_b, add_a, add_b, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output start, base_addr, len, d_ra, d_rb, out_ready,
    input  en_a, en_b, add_a, add_b, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/rom_burst_reader.sv
// Dual-port ROM burst reader: issues paired A/B reads (even/odd offsets) and
// merges the returned words, in address order, into a buffered byte stream.
module rom_burst_reader #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  rom_burst_reader_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   REM_TWO  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_TWO = ADDR_W'(2);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_rem;
  logic              r_enA, r_enB, r_lastA, r_lastB;
  logic [ADDR_W-1:0] r_addA, r_addB;
  logic              r_retA, r_retB, r_retLastA, r_retLastB;

  logic [DATA_W:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr, r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W:0]   w_lenSat;
  logic [CNT_W:0]    w_inFlight;
  logic              w_credit, w_drained;
  logic              w_issue, w_issueB;
  logic [ADDR_W-1:0] w_issueAddr;
  logic [ADDR_W:0]   w_issueRem, w_remNext;
  logic [1:0]        w_pushCnt;
  logic              w_outValid, w_pop;
  logic [DATA_W:0]   w_head;

  assign w_lenSat   = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
  // Every issued word is already owed a FIFO slot, so credit counts the pipeline too.
  assign w_inFlight = {1'b0, r_count} + (CNT_W+1)'(r_enA) + (CNT_W+1)'(r_enB)
                    + (CNT_W+1)'(r_retA) + (CNT_W+1)'(r_retB);
  assign w_credit   = (w_inFlight <= (CNT_W+1)'(FIFO_DEPTH - 2));
  assign w_drained  = (r_count == '0) && !r_enA && !r_enB && !r_retA && !r_retB;

  always_comb begin
    w_next      = r_state;
    w_issue     = 1'b0;
    w_issueAddr = r_ptr;
    w_issueRem  = r_rem;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_lenSat == '0) begin
            w_next = DONE;
          end else begin
            w_issue     = 1'b1;
            w_issueAddr = bus.base_addr;
            w_issueRem  = w_lenSat;
            w_next      = (w_lenSat <= REM_TWO) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_rem <= REM_TWO) w_next = DRAIN;
        end
      end
      DRAIN:   if (w_drained) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_issueB  = w_issue && (w_issueRem >= REM_TWO);
  assign w_remNext = w_issueRem - (w_issueB ? REM_TWO : REM_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_enA      <= 1'b0;
      r_enB      <= 1'b0;
      r_addA     <= '0;
      r_addB     <= '0;
      r_lastA    <= 1'b0;
      r_lastB    <= 1'b0;
      r_retA     <= 1'b0;
      r_retB     <= 1'b0;
      r_retLastA <= 1'b0;
      r_retLastB <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_enA      <= w_issue;
      r_enB      <= w_issueB;
      r_retA     <= r_enA;
      r_retB     <= r_enB;
      r_retLastA <= r_lastA;
      r_retLastB <= r_lastB;
      if (w_issue) begin
        r_addA  <= w_issueAddr;
        r_ptr   <= w_issueAddr + ADDR_TWO;
        r_rem   <= w_remNext;
        r_lastA <= (w_issueRem == REM_ONE);
        r_lastB <= (w_issueRem == REM_TWO);
      end
      if (w_issueB) r_addB <= w_issueAddr + ADDR_ONE;
    end
  end

  // Port B only ever returns alongside port A, so B lands in the slot after A.
  assign w_pushCnt  = {1'b0, r_retA} + {1'b0, r_retB};
  assign w_outValid = (r_count != '0);
  assign w_pop      = w_outValid && bus.out_ready;
  assign w_head     = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (r_retA) r_mem[r_wrPtr] <= {r_retLastA, bus.d_ra};
    if (r_retB) r_mem[r_wrPtr + PTR_ONE] <= {r_retLastB, bus.d_rb};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      r_wrPtr <= r_wrPtr + PTR_W'(w_pushCnt);
      r_rdPtr <= r_rdPtr + PTR_W'(w_pop);
      r_count <= r_count + CNT_W'(w_pushCnt) - CNT_W'(w_pop);
    end
  end

  assign bus.en_a      = r_enA;
  assign bus.en_b      = r_enB;
  assign bus.add_a     = r_addA;
  assign bus.add_b     = r_addB;
  assign bus.out_valid = w_outValid;
  assign bus.out_data  = w_outValid ? w_head[DATA_W-1:0] : '0;
  assign bus.out_last  = w_outValid & w_head[DATA_W];
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);

endmodule
